// File: rtl/delay_line_scheduler.sv
// Sequencer for the SGM line-buffer delay-line chain: CE/reset, end-of-frame drain, window centre.
// Build option DELAY_LINE_SCHEDULER_BORDER_EN enables the win_border edge flag.
module delay_line_scheduler #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int WIN_ROWS   = 3,
  parameter int WIN_COLS   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_sof,
  output logic                          in_ready,
  output logic                          dl_ce,
  output logic                          dl_rst,
  output logic                          pad_sel,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          win_border,
  output logic                          frame_done,
  output logic                          sof_err
);

  localparam int HALF_R    = (WIN_ROWS - 1) / 2;
  localparam int HALF_C    = (WIN_COLS - 1) / 2;
  localparam int FLUSH_LEN = HALF_R * IMG_WIDTH + HALF_C;
  localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int PW = $clog2(NPIX);
  localparam int FW = $clog2(FLUSH_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [PW-1:0] POS_LAST = PW'(NPIX - 1);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [FW-1:0] FL_LAST  = FW'(FLUSH_LEN - 1);
  localparam logic [FW-1:0] FL_FULL  = FW'(FLUSH_LEN);
  localparam logic [FW-1:0] FL_ONE   = FW'(1);
  localparam logic [XW-1:0] X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_HEIGHT - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [FW-1:0] flcnt_q, flcnt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;

  logic          win_valid_q;
  logic [XW-1:0] win_x_q;
  logic [YW-1:0] win_y_q;
  logic          win_border_q;
  logic          frame_done_q;

  logic ready, ce, pad, sof_acc, restart, adv, border_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    flcnt_d = flcnt_q;
    fill_d  = fill_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ready   = 1'b0;
    ce      = 1'b0;
    pad     = 1'b0;
    sof_acc = 1'b0;
    restart = 1'b0;
    adv     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (in_valid && in_sof) begin
          ce      = 1'b1;
          sof_acc = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
        ce    = in_valid;
        if (in_valid && in_sof) begin
          sof_acc = 1'b1;
          restart = 1'b1;
        end else if (in_valid) begin
          if (pos_q == POS_LAST) begin
            pos_d   = '0;
            state_d = S_FLUSH;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        ce  = 1'b1;
        pad = 1'b1;
        if (flcnt_q == FL_LAST) begin
          flcnt_d = '0;
          state_d = S_IDLE;
        end else begin
          flcnt_d = flcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // fill_q saturates once the chain holds enough data for a full window
    adv = ce && !sof_acc && (fill_q == FL_FULL);

    if (sof_acc) begin
      pos_d  = POS_ONE;
      fill_d = FL_ONE;
      cx_d   = '0;
      cy_d   = '0;
    end else if (ce && !adv) begin
      fill_d = fill_q + 1'b1;
    end

    if (adv) begin
      if (cx_q == X_LAST) begin
        cx_d = '0;
        cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

`ifdef DELAY_LINE_SCHEDULER_BORDER_EN
  localparam logic [XW-1:0] X_LO = XW'(HALF_C);
  localparam logic [XW-1:0] X_HI = XW'(IMG_WIDTH - HALF_C);
  localparam logic [YW-1:0] Y_LO = YW'(HALF_R);
  localparam logic [YW-1:0] Y_HI = YW'(IMG_HEIGHT - HALF_R);

  assign border_d = (cx_q < X_LO) || (cx_q >= X_HI) ||
                    (cy_q < Y_LO) || (cy_q >= Y_HI);
`else
  assign border_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pos_q        <= '0;
      flcnt_q      <= '0;
      fill_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_border_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      flcnt_q      <= flcnt_d;
      fill_q       <= fill_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      win_valid_q  <= adv;
      win_border_q <= adv && border_d;
      frame_done_q <= adv && (cx_q == X_LAST) && (cy_q == Y_LAST);
      if (adv) begin
        win_x_q <= cx_q;
        win_y_q <= cy_q;
      end
    end
  end

  assign in_ready   = !rst && ready;
  assign dl_ce      = !rst && ce;
  assign pad_sel    = !rst && pad;
  assign dl_rst     = rst || sof_acc;
  assign sof_err    = !rst && restart;
  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_border = win_border_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Directed bench for delay_line_scheduler: 8x4 image, 3x3 window, 9 drain cycles.
// Vector table for handshake/reset behaviour, scripted frames for multi-cycle cases.
module tb_delay_line_scheduler;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready, dl_ce, dl_rst, pad_sel;
  logic       win_valid, win_border, frame_done, sof_err;
  logic [2:0] win_x;
  logic [1:0] win_y;

  int n_chk  = 0;
  int n_fail = 0;

  int ce_cnt, wv_cnt, pad_cnt, fd_cnt, err_cnt, rstp_cnt, brd_cnt, first_wv;
  int ex, ey;

  always #5 clk = ~clk;

  delay_line_scheduler #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .WIN_ROWS  (3),
    .WIN_COLS  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .dl_ce     (dl_ce),
    .dl_rst    (dl_rst),
    .pad_sel   (pad_sel),
    .win_valid (win_valid),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_border(win_border),
    .frame_done(frame_done),
    .sof_err   (sof_err)
  );

  typedef struct packed {
    logic r, v, s;
    logic rdy, ce, dlr, pad, err, wv;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic exp_border(input int x, input int y);
`ifdef DELAY_LINE_SCHEDULER_BORDER_EN
    return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic reset_mon();
    ce_cnt = 0; wv_cnt = 0; pad_cnt = 0; fd_cnt = 0;
    err_cnt = 0; rstp_cnt = 0; brd_cnt = 0; first_wv = -1;
    ex = 0; ey = 0;
  endtask

  // one clock: drive at negedge, observe 1 time unit later
  task automatic tick(input logic r, input logic v, input logic s);
    @(negedge clk);
    rst = r; in_valid = v; in_sof = s;
    #1;
    if (win_valid) begin
      chk("win_x", win_x, ex);
      chk("win_y", win_y, ey);
      chk("win_border", win_border, exp_border(ex, ey));
      if (win_border) brd_cnt++;
      if (first_wv < 0) first_wv = ce_cnt;
      wv_cnt++;
      if (ex == W - 1) begin ex = 0; ey = (ey + 1) % H; end
      else ex++;
    end
    if (frame_done) begin
      fd_cnt++;
      chk("frame_done_pos", {win_valid, win_x, win_y}, {1'b1, 3'd7, 2'd3});
    end
    if (dl_ce) ce_cnt++;
    if (dl_ce && pad_sel && !in_ready) pad_cnt++;
    if (sof_err) err_cnt++;
    if (dl_rst && !rst) rstp_cnt++;
  endtask

  task automatic run_frame(input bit gap, input logic dv, input int ds);
    tick(1'b0, 1'b1, 1'b1);
    for (int p = 2; p <= NP; p++) begin
      if (gap) tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
    end
    for (int d = 0; d < 20; d++) tick(1'b0, dv, d < ds);
  endtask

  initial begin
    tbl[0]  = 9'b100_001000;
    tbl[1]  = 9'b111_001000;
    tbl[2]  = 9'b000_100000;
    tbl[3]  = 9'b010_100000;
    tbl[4]  = 9'b010_100000;
    tbl[5]  = 9'b010_100000;
    tbl[6]  = 9'b010_100000;
    tbl[7]  = 9'b010_100000;
    tbl[8]  = 9'b011_111000;
    tbl[9]  = 9'b010_110000;
    tbl[10] = 9'b011_111010;
    tbl[11] = 9'b110_001000;
    tbl[12] = 9'b010_100000;

    reset_mon();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].r, tbl[i].v, tbl[i].s);
      chk($sformatf("in_ready[%0d]", i), in_ready, tbl[i].rdy);
      chk($sformatf("dl_ce[%0d]", i), dl_ce, tbl[i].ce);
      chk($sformatf("dl_rst[%0d]", i), dl_rst, tbl[i].dlr);
      chk($sformatf("pad_sel[%0d]", i), pad_sel, tbl[i].pad);
      chk($sformatf("sof_err[%0d]", i), sof_err, tbl[i].err);
      chk($sformatf("win_valid[%0d]", i), win_valid, tbl[i].wv);
    end

    // continuous frame, upstream keeps offering pixels during the drain
    reset_mon();
    run_frame(1'b0, 1'b1, 0);
    chk("cont_first_wv_ce", first_wv, 10);
    chk("cont_wv_cnt", wv_cnt, NP);
    chk("cont_pad_cnt", pad_cnt, 9);
    chk("cont_ce_cnt", ce_cnt, NP + 9);
    chk("cont_frame_done", fd_cnt, 1);
`ifdef DELAY_LINE_SCHEDULER_BORDER_EN
    chk("cont_border_cnt", brd_cnt, 20);
`else
    chk("cont_border_cnt", brd_cnt, 0);
`endif

    // gapped frame, sof during drain must be ignored
    reset_mon();
    run_frame(1'b1, 1'b1, 5);
    chk("gap_first_wv_ce", first_wv, 10);
    chk("gap_wv_cnt", wv_cnt, NP);
    chk("gap_ce_cnt", ce_cnt, NP + 9);
    chk("gap_frame_done", fd_cnt, 1);
    chk("gap_sof_err", err_cnt, 0);
    chk("gap_dl_rst", rstp_cnt, 1);

    // restart at pixel 12
    reset_mon();
    tick(1'b0, 1'b1, 1'b1);
    for (int p = 2; p <= 11; p++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    chk("restart_sof_err", err_cnt, 1);
    chk("restart_dl_rst", rstp_cnt, 2);
    chk("restart_old_wv", wv_cnt, 2);
    reset_mon();
    ce_cnt = 1;
    tick(1'b0, 1'b1, 1'b0);
    chk("restart_suppress", win_valid, 1'b0);
    for (int p = 3; p <= NP; p++) tick(1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 20; d++) tick(1'b0, 1'b0, 1'b0);
    chk("restart_first_wv_ce", first_wv, 10);
    chk("restart_wv_cnt", wv_cnt, NP);
    chk("restart_frame_done", fd_cnt, 1);

    // reset on pad cycle 4
    reset_mon();
    tick(1'b0, 1'b1, 1'b1);
    for (int p = 2; p <= NP; p++) tick(1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rstfl_in_ready", in_ready, 1'b1);
    chk("rstfl_pad_sel", pad_sel, 1'b0);
    chk("rstfl_dl_ce", dl_ce, 1'b0);
    chk("rstfl_win_valid", win_valid, 1'b0);
    for (int d = 0; d < 15; d++) tick(1'b0, 1'b0, 1'b0);
    chk("rstfl_frame_done", fd_cnt, 0);
    chk("rstfl_wv_cnt", wv_cnt, 26);
    chk("rstfl_pad_cnt", pad_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_line_scheduler.md
Name: delay_line_scheduler

Overview:
- Controller that sequences the RAM-based delay lines forming the SGM line buffer / window generator.
- Accepts a raster pixel stream and drives the shared clock-enable and reset of the delay-line chain.
- Tracks raster position and, at end of frame, injects padding cycles to drain the chain.
- Reports the image coordinate of the window centre currently at the window output.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=4)
- IMG_HEIGHT, 480, lines per frame (>=2)
- WIN_ROWS, 3, window height, odd, >=3
- WIN_COLS, 3, window width, odd, >=3

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel present on upstream stream
- in_sof  in  1  qualifies the current in_valid pixel as first pixel of a frame
- in_ready  out  1  scheduler accepts a pixel this cycle
- dl_ce  out  1  clock enable to every delay line and window register
- dl_rst  out  1  reset to delay lines (clears address generators)
- pad_sel  out  1  1 = datapath muxes zero pixel into chain instead of upstream data
- win_valid  out  1  window output valid, registered
- win_x  out  clog2(IMG_WIDTH)  centre column of valid window
- win_y  out  clog2(IMG_HEIGHT)  centre row of valid window
- win_border  out  1  window overlaps image edge (see Optional Feature)
- frame_done  out  1  one-cycle pulse, last window of frame emitted
- sof_err  out  1  one-cycle pulse, in_sof arrived mid-frame

Behaviour:
- Derived constants: HALF_R=(WIN_ROWS-1)/2, HALF_C=(WIN_COLS-1)/2, FLUSH_LEN=HALF_R*IMG_WIDTH+HALF_C.
- Reset values: all outputs 0 except dl_rst=1 while rst; FSM=IDLE; all counters 0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=1.
  - in_valid & ~in_sof: pixel dropped, dl_ce=0.
  - in_valid & in_sof: accepted with dl_ce=1, in_pos=1, transition to RUN.
- RUN:
  - in_ready=1, dl_ce=in_valid, pad_sel=0.
  - Input counter in_pos increments per accepted pixel.
  - When the accepted pixel is number IMG_WIDTH*IMG_HEIGHT (last), transition to FLUSH.
- FLUSH:
  - in_ready=0, dl_ce=1, pad_sel=1 for exactly FLUSH_LEN consecutive cycles, then transition to IDLE.
  - Upstream in_valid is ignored (not consumed).
- Stream index n = count of dl_ce cycles since frame start (pixel plus pad).
- Window centre tracking:
  - Centre counters (cx, cy) advance on each dl_ce cycle with n > FLUSH_LEN (n counted after the current cycle).
  - cx wraps IMG_WIDTH-1 -> 0 with cy+1.
- Window output registers:
  - win_valid, win_x, win_y register one cycle after such a dl_ce cycle (matches 1-cycle window register after 2-cycle RAM).
  - Exactly IMG_WIDTH*IMG_HEIGHT win_valid pulses per frame.
- frame_done: asserted in the cycle win_valid presents (IMG_WIDTH-1, IMG_HEIGHT-1).
- dl_rst: asserted for one cycle coincident with the dl_ce of every accepted sof pixel, so delay-line address generators start at 0 each frame; also high during rst.
- Mid-frame sof (in RUN, in_valid & in_sof, in_pos != 0):
  - sof_err pulses.
  - Frame restarts: counters cleared, pixel treated as first pixel, dl_rst pulses.
  - Pending window outputs of the aborted frame are suppressed (win_valid=0 from next cycle until the new frame fills).
- in_sof during FLUSH: ignored, no error.
- Simultaneous last pixel and in_sof: in_sof wins (restart rule).
- rst mid-frame: immediate return to IDLE, no frame_done, no pending win_valid.
- Counters are unsigned, sized by clog2 of their maximum value; no arithmetic overflow permitted.

Optional Feature:
- Macro: DELAY_LINE_SCHEDULER_BORDER_EN.
- Defined: win_border is registered with win_valid and is 1 when any of the following holds:
  - cx<HALF_C
  - cx>=IMG_WIDTH-HALF_C
  - cy<HALF_R
  - cy>=IMG_HEIGHT-HALF_R
  - Aggregation stages use it to mask out-of-image costs.
- Not defined: win_border tied to 0; port remains for a stable interface.

Test Plan:
- Common bench configuration: W=8, H=4, 3x3 window, FLUSH_LEN=9.
- Continuous frame of 32 pixels with sof on first:
  - First win_valid occurs 1 cycle after the 10th dl_ce, with (0,0).
  - 32 win_valid pulses in raster order.
  - 9 pad cycles with in_ready=0.
  - frame_done with (7,3).
- Same frame with in_valid deasserted every other cycle: identical win_x/win_y sequence, dl_ce only on accepted pixels, no extra win_valid.
- in_valid without sof in IDLE for 5 cycles, then sof frame: first 5 pixels dropped (dl_ce=0), frame processed normally.
- sof at pixel 12 of a frame: sof_err pulse, dl_rst pulse, no win_valid until 10th dl_ce of the new frame, then (0,0).
- rst asserted during FLUSH at pad cycle 4: FSM IDLE next cycle, frame_done never fires, win_valid 0.
- DELAY_LINE_SCHEDULER_BORDER_EN defined:
  - win_border=1 for all windows with x in {0,7} or y in {0,3}: 20 of 32 windows.
  - win_border=0 for interior (1..6,1..2): 12 windows.
  - Macro undefined: always 0.
